// File: rtl/march_scheduler_pkg.sv
// march_scheduler_pkg: sizing, fp27 constants, slot states and fp27 compare shared by the ray-slot scheduler
package march_scheduler_pkg;
  localparam int CORDW     = 10;
  localparam int NUM_SLOTS = 8;
  localparam int TAG_W     = 3;
  localparam int MAX_ITER  = 64;
  localparam int ITER_W    = 7;
  typedef logic [26:0] fp27_t;
  localparam fp27_t FP_EPS  = 27'h1E40000;
  localparam fp27_t FP_TMAX = 27'h2240000;
  typedef enum logic [1:0] {S_FREE, S_RUN, S_DONE} slot_state_e;
  function automatic logic fp27_lt(input fp27_t a, input fp27_t b);
    return a[25:0] < b[25:0];
  endfunction
endpackage

// File: rtl/march_scheduler_if.sv
// march_scheduler_if: request (req_*), datapath issue (iss_*), datapath return (ret_*) and result (res_*) channels;
// slave = scheduler side, master = environment side
interface march_scheduler_if;
  import march_scheduler_pkg::*;
  logic             req_valid, req_ready;
  logic [CORDW-1:0] req_px, req_py;
  logic             iss_valid, iss_first;
  logic [TAG_W-1:0] iss_tag;
  logic [CORDW-1:0] iss_px, iss_py;
  logic             ret_valid;
  logic [TAG_W-1:0] ret_tag;
  fp27_t            ret_dist, ret_t;
  logic             res_valid, res_ready, res_hit;
  logic [CORDW-1:0] res_px, res_py;
  logic [ITER_W-1:0] res_iter;
  modport slave (
    input  req_valid, req_px, req_py, ret_valid, ret_tag, ret_dist, ret_t, res_ready,
    output req_ready, iss_valid, iss_tag, iss_first, iss_px, iss_py,
           res_valid, res_px, res_py, res_hit, res_iter
  );
  modport master (
    output req_valid, req_px, req_py, ret_valid, ret_tag, ret_dist, ret_t, res_ready,
    input  req_ready, iss_valid, iss_tag, iss_first, iss_px, iss_py,
           res_valid, res_px, res_py, res_hit, res_iter
  );
endinterface

// File: rtl/march_scheduler_lowest_set_idx.sv
// lowest_set_idx: vec_i -> idx_o (index of lowest set bit, 0 if none), any_o (any bit set)
module lowest_set_idx #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) idx_o = vec_i[i] ? W'(i) : idx_o;
  end
  assign any_o = |vec_i;
endmodule

// File: rtl/march_scheduler.sv
// march_scheduler: ray-slot controller; ports clk, rst_n (async low), bus (slave: req/iss/ret/res channels),
// busy_o (any slot in use or result pending), err_o (sticky: return for a slot not running)
module march_scheduler
  import march_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  march_scheduler_if.slave bus,
  output logic             busy_o,
  output logic             err_o
);
  slot_state_e       state_q [NUM_SLOTS];
  slot_state_e       state_d [NUM_SLOTS];
  logic [CORDW-1:0]  px_q [NUM_SLOTS], px_d [NUM_SLOTS], py_q [NUM_SLOTS], py_d [NUM_SLOTS];
  logic [ITER_W-1:0] iter_q [NUM_SLOTS], iter_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit_q, hit_d, free_vec, done_vec;
  logic [TAG_W-1:0]  free_idx, done_idx, iss_tag_q, iss_tag_d;
  logic              free_any, done_any;
  logic              iss_valid_q, iss_valid_d, iss_first_q, iss_first_d;
  logic [CORDW-1:0]  iss_px_q, iss_px_d, iss_py_q, iss_py_d;
  logic              res_valid_q, res_valid_d, res_hit_q, res_hit_d;
  logic [CORDW-1:0]  res_px_q, res_px_d, res_py_q, res_py_d;
  logic [ITER_W-1:0] res_iter_q, res_iter_d, iter_nx;
  logic              err_q, err_d;
  logic              ret_run, is_hit, is_miss, cont, accept, res_load, res_take;

  always_comb begin
    free_vec = '0;
    done_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_vec[i] = state_q[i] == S_FREE;
      done_vec[i] = state_q[i] == S_DONE;
    end
  end

  lowest_set_idx #(.N(NUM_SLOTS), .W(TAG_W)) u_free_pick (.vec_i(free_vec), .idx_o(free_idx), .any_o(free_any));
  lowest_set_idx #(.N(NUM_SLOTS), .W(TAG_W)) u_done_pick (.vec_i(done_vec), .idx_o(done_idx), .any_o(done_any));

  // Returns for slots that are not running are dropped and only raise err.
  assign ret_run  = bus.ret_valid && state_q[bus.ret_tag] == S_RUN;
  assign iter_nx  = iter_q[bus.ret_tag] + ITER_W'(1);
  assign is_hit   = bus.ret_dist[26] | fp27_lt(bus.ret_dist, FP_EPS);
  assign is_miss  = (~bus.ret_t[26] & (bus.ret_t[25:0] > FP_TMAX[25:0])) | (iter_nx == ITER_W'(MAX_ITER));
  assign cont     = ret_run & ~is_hit & ~is_miss;
  // A continuing ray owns next cycle's issue slot, so no new ray may be accepted alongside it.
  assign bus.req_ready = rst_n & free_any & ~cont;
  assign accept   = bus.req_valid & bus.req_ready;
  assign res_load = ~res_valid_q | bus.res_ready;
  assign res_take = res_load & done_any;

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    iter_d  = iter_q;
    hit_d   = hit_q;
    if (accept) begin
      state_d[free_idx] = S_RUN;
      px_d[free_idx]    = bus.req_px;
      py_d[free_idx]    = bus.req_py;
      iter_d[free_idx]  = '0;
    end
    if (ret_run) begin
      iter_d[bus.ret_tag] = iter_nx;
      hit_d[bus.ret_tag]  = is_hit;
      if (!cont) state_d[bus.ret_tag] = S_DONE;
    end
    if (res_take) state_d[done_idx] = S_FREE;
  end

  assign iss_valid_d = cont | accept;
  assign iss_first_d = ~cont & accept;
  assign iss_tag_d   = cont ? bus.ret_tag : free_idx;
  assign iss_px_d    = cont ? px_q[bus.ret_tag] : bus.req_px;
  assign iss_py_d    = cont ? py_q[bus.ret_tag] : bus.req_py;
  assign res_valid_d = res_load ? done_any : res_valid_q;
  assign res_px_d    = res_take ? px_q[done_idx] : res_px_q;
  assign res_py_d    = res_take ? py_q[done_idx] : res_py_q;
  assign res_hit_d   = res_take ? hit_q[done_idx] : res_hit_q;
  assign res_iter_d  = res_take ? iter_q[done_idx] : res_iter_q;
  assign err_d       = err_q | (bus.ret_valid & ~ret_run);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= S_FREE;
        px_q[i]    <= '0;
        py_q[i]    <= '0;
        iter_q[i]  <= '0;
      end
      hit_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_first_q <= 1'b0;
      iss_tag_q   <= '0;
      iss_px_q    <= '0;
      iss_py_q    <= '0;
      res_valid_q <= 1'b0;
      res_px_q    <= '0;
      res_py_q    <= '0;
      res_hit_q   <= 1'b0;
      res_iter_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      iter_q      <= iter_d;
      hit_q       <= hit_d;
      iss_valid_q <= iss_valid_d;
      iss_first_q <= iss_first_d;
      iss_tag_q   <= iss_tag_d;
      iss_px_q    <= iss_px_d;
      iss_py_q    <= iss_py_d;
      res_valid_q <= res_valid_d;
      res_px_q    <= res_px_d;
      res_py_q    <= res_py_d;
      res_hit_q   <= res_hit_d;
      res_iter_q  <= res_iter_d;
      err_q       <= err_d;
    end
  end

  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_first = iss_first_q;
  assign bus.iss_tag   = iss_tag_q;
  assign bus.iss_px    = iss_px_q;
  assign bus.iss_py    = iss_py_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_px    = res_px_q;
  assign bus.res_py    = res_py_q;
  assign bus.res_hit   = res_hit_q;
  assign bus.res_iter  = res_iter_q;
  assign busy_o        = ~&free_vec | res_valid_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_march_scheduler.sv
// tb_march_scheduler: scoreboard bench with a fixed-latency datapath model driving the return channel
module tb_march_scheduler;
  import march_scheduler_pkg::*;
  typedef struct {
    logic [CORDW-1:0]  px, py;
    logic              hit;
    logic [ITER_W-1:0] iter;
  } res_t;
  typedef struct {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic             first;
    logic [CORDW-1:0] px;
  } dp_t;
  localparam fp27_t ONE   = 27'h1FC0000;
  localparam fp27_t SMALL = 27'h1E00000;
  localparam fp27_t NEG   = 27'h5FC0000;
  localparam fp27_t FAR   = 27'h2280000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;
  march_scheduler_if bus();
  march_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy_o(busy), .err_o(err));
  always #5 clk = ~clk;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   hit_at[1024], neg_at[1024], far_at[1024], iss_cnt[1024];
  int   stepc[NUM_SLOTS];
  int   dp_lat = 1;
  bit   dp_en = 1'b1;
  dp_t  pipe[16];
  dp_t  cur;
  res_t got, e;

  // Datapath model: issue seen in cycle c returns in cycle c+dp_lat.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) pipe[i] = '{default: '0};
      bus.ret_valid = 1'b0;
    end else begin
      if (bus.iss_valid) iss_cnt[bus.iss_px]++;
      for (int i = 15; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = '{bus.iss_valid, bus.iss_tag, bus.iss_first, bus.iss_px};
      cur = pipe[dp_lat];
      if (cur.v) stepc[cur.tag] = cur.first ? 1 : stepc[cur.tag] + 1;
      bus.ret_valid = dp_en && cur.v;
      bus.ret_tag   = cur.tag;
      bus.ret_dist  = (stepc[cur.tag] == hit_at[cur.px]) ? SMALL : (stepc[cur.tag] == neg_at[cur.px]) ? NEG : ONE;
      bus.ret_t     = (stepc[cur.tag] == far_at[cur.px]) ? FAR : ONE;
    end
  end

  // Result monitor: every accepted result is popped from the scoreboard and compared.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.res_valid && bus.res_ready) begin
      got = '{bus.res_px, bus.res_py, bus.res_hit, bus.res_iter};
      n_checks++;
      if (exp_q.size() == 0)
        $display("FAIL result_unexpected: got px=%0d py=%0d hit=%0d iter=%0d, required no result", got.px, got.py, got.hit, got.iter);
      else begin
        e = exp_q.pop_front();
        if (got.px !== e.px || got.py !== e.py || got.hit !== e.hit || got.iter !== e.iter)
          $display("FAIL result: got px=%0d py=%0d hit=%0d iter=%0d, required px=%0d py=%0d hit=%0d iter=%0d",
                   got.px, got.py, got.hit, got.iter, e.px, e.py, e.hit, e.iter);
        else n_pass++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t exp_of(input int px, input int py);
    res_t r;
    r.px = CORDW'(px);
    r.py = CORDW'(py);
    r.hit = 1'b0;
    r.iter = ITER_W'(MAX_ITER);
    for (int s = MAX_ITER; s >= 1; s--) begin
      if (s == far_at[px]) begin r.hit = 1'b0; r.iter = ITER_W'(s); end
      if (s == hit_at[px] || s == neg_at[px]) begin r.hit = 1'b1; r.iter = ITER_W'(s); end
    end
    return r;
  endfunction

  // Entered and left at posedge+2; leaves req_valid asserted so requests can run back to back.
  task automatic send(input int px, input int py, input bit push);
    bit ok = 1'b0;
    if (push) exp_q.push_back(exp_of(px, py));
    bus.req_valid = 1'b1;
    bus.req_px = CORDW'(px);
    bus.req_py = CORDW'(py);
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      ok = bus.req_ready;
      @(posedge clk);
      #2;
    end
    if (!ok) begin n_checks++; $display("FAIL req_accept: px=%0d not accepted within 500 cycles", px); end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      ok = !busy && exp_q.size() == 0;
    end
    @(posedge clk);
    #2;
    n_checks++;
    if (!ok) $display("FAIL idle: busy=%0d pending=%0d, required busy=0 pending=0", busy, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL rst_req_ready: got %0d, required 0", bus.req_ready); else n_pass++;
    n_checks++; if (bus.iss_valid !== 1'b0) $display("FAIL rst_iss_valid: got %0d, required 0", bus.iss_valid); else n_pass++;
    n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL rst_res_valid: got %0d, required 0", bus.res_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL rst_busy_err: got %0d/%0d, required 0/0", busy, err); else n_pass++;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL post_rst_ready: got %0d, required 1", bus.req_ready); else n_pass++;
    @(posedge clk);
    #2;
  endtask

  task automatic test_max_iter();
    dp_lat = 3;
    iss_cnt[3] = 0;
    send(3, 5, 1'b1);
    bus.req_valid = 1'b0;
    wait_idle();
    n_checks++; if (iss_cnt[3] !== MAX_ITER) $display("FAIL max_iter_issues: got %0d, required %0d", iss_cnt[3], MAX_ITER); else n_pass++;
  endtask

  task automatic test_hit_first();
    bit found = 1'b0;
    dp_lat = 2;
    hit_at[7] = 1;
    send(7, 9, 1'b1);
    bus.req_valid = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = bus.ret_valid;
    end
    n_checks++; if (!found) $display("FAIL hit_first_ret: got no return, required one within 20 cycles"); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL hit_first_early: got res_valid=%0d, required 0", bus.res_valid); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_hit !== 1'b1 || bus.res_iter !== 7'd1)
      $display("FAIL hit_first_res: got v=%0d hit=%0d iter=%0d, required 1/1/1", bus.res_valid, bus.res_hit, bus.res_iter);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_classify();
    dp_lat = 2;
    neg_at[50] = 3;
    send(50, 51, 1'b1);
    bus.req_valid = 1'b0;
    wait_idle();
    far_at[60] = 2;
    send(60, 61, 1'b1);
    bus.req_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    bit ok = 1'b0;
    dp_lat = 6;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hit_at[100 + i] = 1;
      send(100 + i, 200 + i, 1'b1);
    end
    hit_at[108] = 4;
    exp_q.push_back(exp_of(108, 208));
    bus.req_px = 10'd108;
    bus.req_py = 10'd208;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL b2b_full: got req_ready=%0d, required 0", bus.req_ready); else n_pass++;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk);
      #2;
      @(negedge clk);
      ok = bus.req_ready;
    end
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    n_checks++; if (!ok) $display("FAIL b2b_ninth: got no acceptance, required one within 50 cycles"); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b1 || bus.res_px !== exp_q[0].px || bus.res_py !== exp_q[0].py || bus.res_iter !== exp_q[0].iter || busy !== 1'b1)
        $display("FAIL b2b_stall: got v=%0d px=%0d py=%0d iter=%0d busy=%0d, required 1/%0d/%0d/%0d/1",
                 bus.res_valid, bus.res_px, bus.res_py, bus.res_iter, busy, exp_q[0].px, exp_q[0].py, exp_q[0].iter);
      else n_pass++;
    end
    @(posedge clk);
    #2;
    bus.res_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_coincident();
    bit found = 1'b0;
    dp_lat = 1;
    hit_at[31] = 1;
    exp_q.push_back(exp_of(31, 32));
    send(30, 33, 1'b0);
    exp_q.push_back(exp_of(30, 33));
    bus.req_valid = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      found = bus.ret_valid;
      if (!found) begin @(posedge clk); #2; end
    end
    n_checks++; if (!found) $display("FAIL coinc_ret: got no return, required one within 20 cycles"); else n_pass++;
    bus.req_valid = 1'b1;
    bus.req_px = 10'd31;
    bus.req_py = 10'd32;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL coinc_block: got req_ready=%0d, required 0", bus.req_ready); else n_pass++;
    @(posedge clk);
    #2;
    n_checks++;
    if (bus.iss_valid !== 1'b1 || bus.iss_first !== 1'b0 || bus.iss_px !== 10'd30)
      $display("FAIL coinc_reissue: got v=%0d first=%0d px=%0d, required 1/0/30", bus.iss_valid, bus.iss_first, bus.iss_px);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL coinc_next: got req_ready=%0d, required 1", bus.req_ready); else n_pass++;
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.iss_valid !== 1'b1 || bus.iss_first !== 1'b1 || bus.iss_px !== 10'd31)
      $display("FAIL coinc_new_issue: got v=%0d first=%0d px=%0d, required 1/1/31", bus.iss_valid, bus.iss_first, bus.iss_px);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_err();
    dp_en = 1'b0;
    bus.ret_valid = 1'b1;
    bus.ret_tag = 3'd5;
    bus.ret_dist = ONE;
    bus.ret_t = ONE;
    @(posedge clk);
    #2;
    @(negedge clk);
    n_checks++; if (err !== 1'b1) $display("FAIL err_set: got %0d, required 1", err); else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || bus.iss_valid !== 1'b0 || bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL err_nochange: got busy=%0d iss=%0d res=%0d rdy=%0d, required 0/0/0/1", busy, bus.iss_valid, bus.res_valid, bus.req_ready);
    else n_pass++;
    @(posedge clk);
    #2;
    dp_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    dp_lat = 1;
    send(40, 41, 1'b0);
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0 || bus.iss_valid !== 1'b0 || bus.res_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL mid_rst: got rdy=%0d iss=%0d res=%0d busy=%0d err=%0d, required all 0",
               bus.req_ready, bus.iss_valid, bus.res_valid, busy, err);
    else n_pass++;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.iss_valid !== 1'b0)
      $display("FAIL mid_rst_release: got rdy=%0d busy=%0d iss=%0d, required 1/0/0", bus.req_ready, busy, bus.iss_valid);
    else n_pass++;
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_px = '0;
    bus.req_py = '0;
    bus.ret_valid = 1'b0;
    bus.ret_tag = '0;
    bus.ret_dist = '0;
    bus.ret_t = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_max_iter();
    test_hit_first();
    test_classify();
    test_back_to_back();
    test_coincident();
    test_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
